// File: rtl/pim_mem_master_pkg.sv
// Shared constants and types for the PIM word-memory initiator.
package pim_mem_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_RD_HOLD,
        ST_NEXT
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/pim_mem_master_if.sv
// Command, write/read stream and memory-side signals of the PIM memory master.
interface pim_mem_master_if #(
    parameter int unsigned ADDR_W = pim_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = pim_mem_pkg::DATA_W,
    parameter int unsigned LEN_W  = pim_mem_pkg::LEN_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              busy;
    logic              err_timeout;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, mem_data_in, mem_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, busy, err_timeout,
        output mem_address, mem_data_out, mem_write, mem_read
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, mem_data_in, mem_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, busy, err_timeout,
        input  mem_address, mem_data_out, mem_write, mem_read
    );
endinterface

// File: rtl/pim_mem_master_ready_tracker.sv
// Follows mem_ready after an issue: ack when it falls, done when it rises,
// timeout when either phase overstays its limit.
module pim_ready_tracker #(
    parameter int unsigned ACK_TIMEOUT  = 8,
    parameter int unsigned DONE_TIMEOUT = 64
) (
    input  logic clock,
    input  logic rst,
    input  logic ack_wait_i,
    input  logic done_wait_i,
    input  logic mem_ready_i,
    output logic ack_o,
    output logic done_o,
    output logic timeout_o
);
    localparam int unsigned MAX_T = (DONE_TIMEOUT > ACK_TIMEOUT) ? DONE_TIMEOUT : ACK_TIMEOUT;
    localparam int unsigned CNT_W = $clog2(MAX_T) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             limit_hit;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The counter restarts on every phase change, so WAIT_DONE gets its full budget.
    always_comb begin
        ack_o     = ack_wait_i && !mem_ready_i;
        done_o    = done_wait_i && mem_ready_i;
        limit_hit = 1'b0;
        if (ack_wait_i) begin
            limit_hit = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
        end else if (done_wait_i) begin
            limit_hit = (cnt_q == CNT_W'(DONE_TIMEOUT - 1));
        end
        timeout_o = limit_hit && !ack_o && !done_o;
        cnt_d     = cnt_q + CNT_W'(1);
        if (!(ack_wait_i || done_wait_i) || ack_o || done_o || timeout_o) begin
            cnt_d = '0;
        end
    end
endmodule

// File: rtl/pim_mem_master.sv
// Burst initiator for the PIM word memory: one ready-paced access per word,
// write data streamed in, read data streamed out.
module pim_mem_master #(
    parameter int unsigned ADDR_W       = pim_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W       = pim_mem_pkg::DATA_W,
    parameter int unsigned LEN_W        = pim_mem_pkg::LEN_W,
    parameter int unsigned ACK_TIMEOUT  = 8,
    parameter int unsigned DONE_TIMEOUT = 64
) (
    input logic              clock,
    input logic              rst,
    pim_mem_master_if.master bus
);
    import pim_mem_pkg::*;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              strobe;
    logic              trk_ack, trk_done, trk_timeout;

    pim_ready_tracker #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) u_tracker (
        .clock      (clock),
        .rst        (rst),
        .ack_wait_i (state_q == ST_WAIT_ACK),
        .done_wait_i(state_q == ST_WAIT_DONE),
        .mem_ready_i(bus.mem_ready),
        .ack_o      (trk_ack),
        .done_o     (trk_done),
        .timeout_o  (trk_timeout)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_READ;
            addr_q   <= '0;
            remain_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        strobe   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d     = bus.cmd_write ? OP_WRITE : OP_READ;
                    addr_d   = bus.cmd_addr;
                    remain_d = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
                    err_d    = 1'b0;
                    state_d  = bus.cmd_write ? ST_FETCH : ST_ISSUE;
                end
            end
            ST_FETCH: begin
                if (bus.wr_valid) begin
                    wdata_d = bus.wr_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ready) begin
                    strobe  = 1'b1;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (trk_ack) begin
                    state_d = ST_WAIT_DONE;
                end else if (trk_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_WAIT_DONE: begin
                if (trk_done) begin
                    if (op_q == OP_READ) begin
                        rdata_d = bus.mem_data_in;
                        state_d = ST_RD_HOLD;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (trk_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_RD_HOLD: begin
                if (bus.rd_ready) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                remain_d = remain_q - LEN_W'(1);
                addr_d   = addr_q + ADDR_W'(1);
                if (remain_q == LEN_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = (op_q == OP_WRITE) ? ST_FETCH : ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign bus.cmd_ready    = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.wr_ready     = (state_q == ST_FETCH);
    assign bus.rd_valid     = (state_q == ST_RD_HOLD);
    assign bus.rd_data      = rdata_q;
    assign bus.done         = (state_q == ST_NEXT) && (remain_q == LEN_W'(1));
    assign bus.err_timeout  = err_q;
    assign bus.mem_address  = addr_q;
    assign bus.mem_data_out = wdata_q;
    assign bus.mem_write    = strobe && (op_q == OP_WRITE);
    assign bus.mem_read     = strobe && (op_q == OP_READ);
endmodule

// File: tb/tb_pim_mem_master.sv
// Scoreboard bench for pim_mem_master with a ready-handshake memory model.
module tb_pim_mem_master;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 6;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    pim_mem_master_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    pim_mem_master #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .LEN_W       (LW),
        .ACK_TIMEOUT (8),
        .DONE_TIMEOUT(64)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    acc_t          exp_acc[$];
    logic [DW-1:0] exp_rd[$];
    logic [DW-1:0] wr_words[$];
    logic [DW-1:0] mem [0:1023];

    int   wr_count = 0, rd_count = 0, rd_words = 0, done_cnt = 0, wr_taken = 0;
    bit   never_ack = 1'b0;
    int   mphase = 0, lo_left = 0;
    acc_t cur, e;
    int   stall_word = -1, stall_left = 0, rd_count_at_hold = 0;
    bit   holding = 1'b0;
    logic [DW-1:0] held;
    bit   wr_taking = 1'b0;
    int   wr_gap = 0, gap_len = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: ready drops one cycle after a strobe and returns three cycles later.
    always @(negedge clock) begin
        if (rst) begin
            bus.mem_ready   = 1'b1;
            bus.mem_data_in = '0;
            mphase          = 0;
        end else begin
            case (mphase)
                0: if (bus.mem_write || bus.mem_read) begin
                    check_eq("strobe_excl", 64'(bus.mem_write & bus.mem_read), 0);
                    check_eq("rd_overlap", 64'(bus.rd_valid), 0);
                    cur.wr   = bus.mem_write;
                    cur.addr = bus.mem_address;
                    cur.data = bus.mem_data_out;
                    if (cur.wr) begin
                        wr_count++;
                        check_eq("wr_latched", 64'(wr_taken >= wr_count), 1);
                    end else begin
                        rd_count++;
                    end
                    if (exp_acc.size() == 0) begin
                        check_eq("unexp_strobe", 64'({bus.mem_write, bus.mem_read}), 0);
                    end else begin
                        e = exp_acc.pop_front();
                        check_eq("strobe_op", 64'(cur.wr), 64'(e.wr));
                        check_eq("strobe_addr", 64'(cur.addr), 64'(e.addr));
                        if (e.wr) check_eq("strobe_data", 64'(cur.data), 64'(e.data));
                    end
                    mphase = 1;
                end
                1: begin
                    check_eq("strobe_1cyc", 64'({bus.mem_write, bus.mem_read}), 0);
                    if (never_ack) begin
                        mphase = 0;
                    end else begin
                        bus.mem_ready = 1'b0;
                        lo_left       = 3;
                        mphase        = 2;
                    end
                end
                default: begin
                    lo_left--;
                    if (lo_left == 0) begin
                        bus.mem_ready = 1'b1;
                        if (cur.wr) mem[cur.addr] = cur.data;
                        else        bus.mem_data_in = mem[cur.addr];
                        mphase = 0;
                    end
                end
            endcase
        end
    end

    // Read consumer, with an optional stall on one chosen word.
    always @(negedge clock) begin
        if (rst) begin
            bus.rd_ready = 1'b0;
            holding      = 1'b0;
        end else if (holding) begin
            bus.rd_ready = 1'b0;
            check_eq("hold_valid", 64'(bus.rd_valid), 1);
            check_eq("hold_data", 64'(bus.rd_data), 64'(held));
            check_eq("hold_noread", 64'(rd_count), 64'(rd_count_at_hold));
            stall_left--;
            if (stall_left == 0) holding = 1'b0;
        end else if (bus.rd_valid) begin
            if (rd_words == stall_word && stall_left > 0) begin
                bus.rd_ready     = 1'b0;
                holding          = 1'b1;
                held             = bus.rd_data;
                rd_count_at_hold = rd_count;
                stall_left--;
            end else begin
                bus.rd_ready = 1'b1;
                if (exp_rd.size() == 0) check_eq("unexp_rd", 64'(bus.rd_valid), 0);
                else                    check_eq("rd_data", 64'(bus.rd_data), 64'(exp_rd.pop_front()));
                rd_words++;
            end
        end else begin
            bus.rd_ready = 1'b0;
        end
    end

    // Write producer with a configurable idle gap between words.
    always @(negedge clock) begin
        if (rst) begin
            bus.wr_valid = 1'b0;
            bus.wr_data  = '0;
            wr_taking    = 1'b0;
            wr_gap       = 0;
        end else begin
            if (wr_taking) begin
                void'(wr_words.pop_front());
                bus.wr_valid = 1'b0;
                wr_gap       = gap_len;
            end
            if (!bus.wr_valid && wr_words.size() > 0) begin
                if (wr_gap > 0) begin
                    wr_gap--;
                end else begin
                    bus.wr_valid = 1'b1;
                    bus.wr_data  = wr_words[0];
                end
            end
            wr_taking = bus.wr_valid && bus.wr_ready;
            if (wr_taking) wr_taken++;
        end
    end

    always @(negedge clock) begin
        if (!rst && bus.done) done_cnt++;
    end

    task automatic send_cmd(input bit wr, input logic [AW-1:0] addr, input int len,
                            input int gap, input logic [DW-1:0] base);
        int            n;
        int            t;
        logic [AW-1:0] a;
        acc_t          x;
        n = (len == 0) ? 1 : len;
        a = addr;
        for (int i = 0; i < n; i++) begin
            x.wr   = wr;
            x.addr = a;
            x.data = wr ? base + DW'(i) : '0;
            exp_acc.push_back(x);
            if (wr) wr_words.push_back(x.data);
            else if (!never_ack) exp_rd.push_back(mem[a]);
            a = a + AW'(1);
        end
        gap_len = gap;
        t = 0;
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        check_eq("cmd_ready_wait", 64'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LW'(len);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int t;
        start = done_cnt;
        t     = 0;
        while (done_cnt == start && t < budget) begin
            @(negedge clock);
            t++;
        end
        check_eq(tag, 64'(done_cnt - start), 1);
        @(negedge clock);
    endtask

    int w0, r0, rw0, d0, t;

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | DW'(i);
        repeat (3) @(negedge clock);

        check_eq("rst_cmd_ready", 64'(bus.cmd_ready), 1);
        check_eq("rst_outs", 64'({bus.busy, bus.wr_ready, bus.rd_valid, bus.done,
                                  bus.err_timeout, bus.mem_write, bus.mem_read}), 0);
        check_eq("rst_addr", 64'(bus.mem_address), 0);
        check_eq("rst_data", 64'({bus.rd_data, bus.mem_data_out}), 0);
        rst = 1'b0;
        @(negedge clock);

        // Single write
        w0 = wr_count;
        send_cmd(1'b1, 10'h010, 1, 0, 32'hDEADBEEF);
        wait_done("t1_done", 200);
        check_eq("t1_writes", 64'(wr_count - w0), 1);
        check_eq("t1_err", 64'(bus.err_timeout), 0);
        check_eq("t1_mem", 64'(mem[10'h010]), 64'h0000_0000_DEAD_BEEF);

        // Read burst wrapping the address space
        rw0 = rd_words;
        send_cmd(1'b0, 10'h3FE, 4, 0, '0);
        wait_done("t2_done", 200);
        check_eq("t2_words", 64'(rd_words - rw0), 4);
        check_eq("t2_queues", 64'(exp_acc.size() + exp_rd.size()), 0);

        // Read burst with consumer stall on the second word
        rw0        = rd_words;
        stall_word = rd_words + 1;
        stall_left = 5;
        send_cmd(1'b0, 10'h100, 4, 0, '0);
        wait_done("t3_done", 300);
        check_eq("t3_words", 64'(rd_words - rw0), 4);
        check_eq("t3_stalled", 64'(stall_left), 0);
        stall_word = -1;

        // Memory never acknowledges: each word times out, burst still completes
        never_ack = 1'b1;
        r0  = rd_count;
        rw0 = rd_words;
        send_cmd(1'b0, 10'h080, 2, 0, '0);
        t = 0;
        while (!bus.mem_read && t < 20) begin
            @(negedge clock);
            t++;
        end
        check_eq("t4_strobe", 64'(bus.mem_read), 1);
        repeat (8) @(negedge clock);
        check_eq("t4_err_pre", 64'(bus.err_timeout), 0);
        @(negedge clock);
        check_eq("t4_err_set", 64'(bus.err_timeout), 1);
        check_eq("t4_busy", 64'({bus.busy, bus.done}), 64'b10);
        wait_done("t4_done", 200);
        check_eq("t4_err_hold", 64'(bus.err_timeout), 1);
        check_eq("t4_reads", 64'(rd_count - r0), 2);
        check_eq("t4_no_rdvalid", 64'(rd_words - rw0), 0);
        never_ack = 1'b0;

        // Write burst with gaps in write data; new command clears err_timeout
        w0 = wr_count;
        send_cmd(1'b1, 10'h200, 3, 2, 32'($urandom()));
        check_eq("t5_err_clr", 64'(bus.err_timeout), 0);
        wait_done("t5_done", 300);
        check_eq("t5_writes", 64'(wr_count - w0), 3);
        check_eq("t5_queues", 64'(exp_acc.size() + wr_words.size()), 0);

        // Reset while waiting for completion
        send_cmd(1'b0, 10'h050, 2, 0, '0);
        t = 0;
        while (bus.mem_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        check_eq("t6_busy_pre", 64'(bus.busy), 1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async", 64'({bus.busy, bus.mem_read, bus.mem_write, bus.rd_valid}), 0);
        check_eq("t6_cmd_ready", 64'(bus.cmd_ready), 1);
        exp_acc.delete();
        exp_rd.delete();
        wr_words.delete();
        repeat (2) @(negedge clock);
        check_eq("t6_no_done", 64'(done_cnt - d0), 0);
        rst = 1'b0;
        @(negedge clock);

        // Recovery after reset; len 0 behaves as a single word
        rw0 = rd_words;
        send_cmd(1'b0, 10'h3FF, 0, 0, '0);
        wait_done("t7_done", 200);
        check_eq("t7_words", 64'(rd_words - rw0), 1);
        check_eq("t7_queues", 64'(exp_acc.size() + exp_rd.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
